// File: rtl/accel_fabric_arb_if.sv
// Shared transaction types and the requester/fabric bundle of the accel fabric arbiter.
package accel_fabric_pkg;
    typedef logic [7:0] t_tile_id;
    typedef logic [4:0] t_fab_ready;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR     = 3'd1;
    localparam logic [2:0] OP_RD     = 3'd2;
    localparam logic [2:0] OP_RD_RSP = 3'd3;
    localparam logic [2:0] OP_WR_RSP = 3'd4;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [7:0]  requestor_id;
        logic [31:0] addr;
        logic [31:0] data;
    } t_tile_trans;
endpackage

interface accel_fabric_arb_if #(
    parameter int NUM_REQ = 2
);
    import accel_fabric_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    t_tile_trans [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_fabric_valid;
    t_tile_trans               out_fabric;
    logic                      in_fabric_valid;
    t_tile_trans               in_fabric;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [31:0]               rsp_data;

    modport slave (
        input  req_valid, req, in_fabric_valid, in_fabric,
        output req_ready, out_fabric_valid, out_fabric, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req, in_fabric_valid, in_fabric,
        input  req_ready, out_fabric_valid, out_fabric, rsp_valid, rsp_data
    );
endinterface

// File: rtl/accel_fabric_arb.sv
// Round-robin arbiter for the accel core's outbound fabric port, with a read-tag
// FIFO that routes in-order RD_RSP data back to whichever requester issued the read.
module accel_fabric_arb
    import accel_fabric_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 4,
    parameter int NUM_REQ            = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  t_tile_id                            local_tile_id_i,
    input  t_fab_ready                          fab_ready_i,
    accel_fabric_arb_if.slave                   bus,
    output logic [$clog2(MAX_RD_OUTSTANDING):0] rd_outstanding_o,
    output logic                                rsp_err_o
);
    localparam int PW = $clog2(MAX_RD_OUTSTANDING);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(MAX_RD_OUTSTANDING);

    logic [PW:0]                   count_q, count_d;
    logic [PW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [MAX_RD_OUTSTANDING-1:0] tag_q;
    logic                          rr_q, rr_d;
    logic                          out_valid_q;
    t_tile_trans                   out_q, out_d;
    logic                          err_q, err_d;

    logic               issue_ok, fifo_full, fifo_empty;
    logic [NUM_REQ-1:0] elig, gnt;
    logic               gnt_any, gnt_idx, push, pop, rsp_is_rd;
    logic               unused_in_fields;

    // The output stage presents each request for exactly one cycle, so it is
    // always free or draining; issue depends only on fabric readiness.
    always_comb begin
        issue_ok   = !rst_i && (fab_ready_i == 5'b11111);
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = issue_ok && bus.req_valid[i] &&
                      (!fifo_full || (bus.req[i].opcode != OP_RD));
        end
    end

    always_comb begin
        gnt = elig;
        if (&elig) begin
            gnt        = '0;
            gnt[rr_q]  = 1'b1;
        end
        gnt_any = |gnt;
        gnt_idx = gnt[1];
        rr_d    = gnt_any ? !gnt_idx : rr_q;
        out_d   = bus.req[gnt_idx];
        out_d.requestor_id = 8'(local_tile_id_i);
        push    = gnt_any && (bus.req[gnt_idx].opcode == OP_RD);
    end

    always_comb begin
        rsp_is_rd     = bus.in_fabric_valid && (bus.in_fabric.opcode == OP_RD_RSP);
        pop           = rsp_is_rd && !fifo_empty;
        err_d         = err_q || (rsp_is_rd && fifo_empty);
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (pop) begin
            bus.rsp_valid[tag_q[rd_ptr_q]] = 1'b1;
            bus.rsp_data                   = bus.in_fabric.data;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_q       <= '0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            rr_q        <= rr_d;
            out_valid_q <= gnt_any;
            err_q       <= err_d;
            if (gnt_any) begin
                out_q <= out_d;
            end
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign bus.req_ready        = gnt;
    assign bus.out_fabric_valid = out_valid_q;
    assign bus.out_fabric       = out_q;
    assign rd_outstanding_o     = count_q;
    assign rsp_err_o            = err_q;
    assign unused_in_fields     = ^{bus.in_fabric.requestor_id, bus.in_fabric.addr};
endmodule

// File: tb/tb_accel_fabric_arb.sv
// Directed bench for accel_fabric_arb: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_accel_fabric_arb;
    import accel_fabric_pkg::*;

    localparam int MAXR = 4;

    logic       clk = 1'b0;
    logic       rst;
    t_tile_id   tile;
    t_fab_ready fab;
    logic [2:0] rd_out;
    logic       err;

    accel_fabric_arb_if #(.NUM_REQ(2)) bus ();

    accel_fabric_arb #(.MAX_RD_OUTSTANDING(MAXR), .NUM_REQ(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .local_tile_id_i  (tile),
        .fab_ready_i      (fab),
        .bus              (bus),
        .rd_outstanding_o (rd_out),
        .rsp_err_o        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic t_tile_trans mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        t_tile_trans t;
        t.opcode       = op;
        t.requestor_id = 8'hAA;
        t.addr         = a;
        t.data         = d;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outstanding reads as a queue of requester indices.
    int          tagq[$];
    int          rr_m = 0;
    logic        m_err = 1'b0;
    logic        exp_ov = 1'b0;
    t_tile_trans exp_out = '0;

    always @(negedge clk) begin
        int          g;
        logic [1:0]  el;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd;
        if (rst) begin
            chk("m_rst_ready", bus.req_ready, 2'b00);
            chk("m_rst_out_valid", bus.out_fabric_valid, 1'b0);
            chk("m_rst_out", bus.out_fabric, '0);
            chk("m_rst_rsp_valid", bus.rsp_valid, 2'b00);
            chk("m_rst_rsp_data", bus.rsp_data, 32'h0);
            chk("m_rst_count", rd_out, 3'd0);
            chk("m_rst_err", err, 1'b0);
            tagq.delete();
            rr_m    = 0;
            m_err   = 1'b0;
            exp_ov  = 1'b0;
            exp_out = '0;
        end else begin
            chk("m_out_valid", bus.out_fabric_valid, exp_ov);
            if (exp_ov) chk("m_out_trans", bus.out_fabric, exp_out);
            chk("m_rd_outstanding", rd_out, tagq.size());
            chk("m_rsp_err", err, m_err);
            for (int i = 0; i < 2; i++) begin
                el[i] = (fab == 5'b11111) && bus.req_valid[i] &&
                        ((bus.req[i].opcode != OP_RD) || (tagq.size() < MAXR));
            end
            if (el == 2'b11)  g = rr_m;
            else if (el[0])   g = 0;
            else if (el[1])   g = 1;
            else              g = -1;
            chk("m_req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
            exp_rv = 2'b00;
            exp_rd = 32'h0;
            if (bus.in_fabric_valid && bus.in_fabric.opcode == OP_RD_RSP) begin
                if (tagq.size() > 0) begin
                    exp_rv = 2'(1 << tagq[0]);
                    exp_rd = bus.in_fabric.data;
                    void'(tagq.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            chk("m_rsp_valid", bus.rsp_valid, exp_rv);
            chk("m_rsp_data", bus.rsp_data, exp_rd);
            if (g >= 0) begin
                if (bus.req[g].opcode == OP_RD) tagq.push_back(g);
                exp_out              = bus.req[g];
                exp_out.requestor_id = tile;
                rr_m                 = 1 - g;
            end
            exp_ov = (g >= 0);
        end
    end

    logic [1:0]  alt [6]   = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] il_d [3]  = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hC0C0_0002};
    logic [1:0]  il_v [3]  = '{2'b01, 2'b10, 2'b01};

    initial begin
        rst                 = 1'b1;
        tile                = 8'h22;
        fab                 = 5'b11111;
        bus.req_valid       = 2'b00;
        bus.req[0]          = '0;
        bus.req[1]          = '0;
        bus.in_fabric_valid = 1'b0;
        bus.in_fabric       = '0;

        @(negedge clk);
        chk("reset_out_valid", bus.out_fabric_valid, 1'b0);
        chk("reset_count", rd_out, 3'd0);
        chk("reset_err", err, 1'b0);
        step();
        rst = 1'b0;

        // Both requesters stream WRs: strict alternation starting at requester 0.
        bus.req[0]    = mk(OP_WR, 32'h1000_0000, 32'h0000_0001);
        bus.req[1]    = mk(OP_WR, 32'h1000_0004, 32'h0000_0002);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("alt_grant", bus.req_ready, alt[k]);
            step();
        end
        bus.req_valid = 2'b00;

        // Single WR from requester 0.
        bus.req[0]    = mk(OP_WR, 32'h2200_0100, 32'hDEAD_BEEF);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("wr_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("wr_out_valid", bus.out_fabric_valid, 1'b1);
        chk("wr_out_addr", bus.out_fabric.addr, 32'h2200_0100);
        chk("wr_out_data", bus.out_fabric.data, 32'hDEAD_BEEF);
        chk("wr_out_id", bus.out_fabric.requestor_id, 8'h22);
        chk("wr_out_op", bus.out_fabric.opcode, OP_WR);
        chk("wr_count", rd_out, 3'd0);
        step();

        // Requester 1 issues 5 RDs; only 4 fit.
        bus.req[1]    = mk(OP_RD, 32'h3000_0000, 32'h0);
        bus.req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_accept", bus.req_ready, 2'b10);
            chk("rd_count", rd_out, 3'(k));
            step();
        end
        @(negedge clk);
        chk("rd_full_hold", bus.req_ready, 2'b00);
        chk("rd_full_count", rd_out, 3'd4);
        step();
        @(negedge clk);
        chk("rd_full_hold2", bus.req_ready, 2'b00);
        step();
        bus.in_fabric_valid = 1'b1;
        bus.in_fabric       = mk(OP_RD_RSP, 32'h0, 32'h1234_5678);
        @(negedge clk);
        chk("rsp1_valid", bus.rsp_valid, 2'b10);
        chk("rsp1_data", bus.rsp_data, 32'h1234_5678);
        chk("rsp1_no_same_cycle_grant", bus.req_ready, 2'b00);
        step();
        bus.in_fabric_valid = 1'b0;
        @(negedge clk);
        chk("rd5_grant", bus.req_ready, 2'b10);
        chk("rd5_count", rd_out, 3'd3);
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("rd5_count_after", rd_out, 3'd4);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.in_fabric_valid = 1'b1;
            bus.in_fabric       = mk(OP_RD_RSP, 32'h0, 32'hC000_0000 + 32'(k));
            @(negedge clk);
            chk("drain_valid", bus.rsp_valid, 2'b10);
            chk("drain_data", bus.rsp_data, 32'hC000_0000 + 32'(k));
            step();
        end
        bus.in_fabric_valid = 1'b0;
        @(negedge clk);
        chk("drain_count", rd_out, 3'd0);
        step();

        // Interleaved RDs 0,1,0, responses three cycles after each grant.
        bus.req[0]    = mk(OP_RD, 32'h4000_0000, 32'h0);
        bus.req[1]    = mk(OP_RD, 32'h4000_0004, 32'h0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("il_grant0", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("il_grant1", bus.req_ready, 2'b10);
        step();
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("il_grant2", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            bus.in_fabric_valid = 1'b1;
            bus.in_fabric       = mk(OP_RD_RSP, 32'h0, il_d[k]);
            @(negedge clk);
            chk("il_rsp_valid", bus.rsp_valid, il_v[k]);
            chk("il_rsp_data", bus.rsp_data, il_d[k]);
            step();
        end
        bus.in_fabric_valid = 1'b0;

        // Fabric back-pressure for three cycles with both requesting.
        bus.req[0]    = mk(OP_WR, 32'h5000_0000, 32'h5555_0000);
        bus.req[1]    = mk(OP_WR, 32'h5000_0004, 32'h5555_0001);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("bp_pre_grant", bus.req_ready, 2'b10);
        step();
        fab = 5'b11110;
        @(negedge clk);
        chk("bp_held_valid", bus.out_fabric_valid, 1'b1);
        chk("bp_no_grant0", bus.req_ready, 2'b00);
        step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_out_idle", bus.out_fabric_valid, 1'b0);
            chk("bp_no_grant", bus.req_ready, 2'b00);
            step();
        end
        fab = 5'b11111;
        @(negedge clk);
        chk("bp_resume", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;

        // Stray RD_RSP with nothing outstanding.
        bus.in_fabric_valid = 1'b1;
        bus.in_fabric       = mk(OP_RD_RSP, 32'h0, 32'hBAD0_0000);
        @(negedge clk);
        chk("stray_no_rsp", bus.rsp_valid, 2'b00);
        step();
        bus.in_fabric_valid = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1'b1);
        step();
        @(negedge clk);
        chk("stray_err_sticky", err, 1'b1);
        step();

        // Reset with two reads in flight.
        bus.req[0]    = mk(OP_RD, 32'h6000_0000, 32'h0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("pre_rst_grant0", bus.req_ready, 2'b01);
        step();
        @(negedge clk);
        chk("pre_rst_grant1", bus.req_ready, 2'b01);
        step();
        chk("pre_rst_count", rd_out, 3'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_count", rd_out, 3'd0);
        chk("async_rst_out_valid", bus.out_fabric_valid, 1'b0);
        chk("async_rst_ready", bus.req_ready, 2'b00);
        chk("async_rst_err", err, 1'b0);
        @(negedge clk);
        step();
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        bus.in_fabric_valid = 1'b1;
        bus.in_fabric       = mk(OP_RD_RSP, 32'h0, 32'h7777_0000);
        @(negedge clk);
        chk("post_rst_rsp_dropped", bus.rsp_valid, 2'b00);
        step();
        bus.in_fabric_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_err", err, 1'b1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/accel_fabric_arb.md
# accel_fabric_arb

Shares the accel core's single outbound fabric port (OutFabricQ505H) between two requesters: the mini_core data-memory path (requester 0) and the accelerator engine (requester 1). Round-robin arbitration, registered output stage, a read-tag FIFO that steers in-order RD_RSP traffic back to the issuing requester, and a bound on outstanding reads. Sits inside accel_core_top between the requesters and the fabric interface.

## Interface
- MAX_RD_OUTSTANDING, 4: read-tag FIFO depth (power of 2, 2..16); also the maximum number of in-flight reads.
- NUM_REQ, 2: number of requesters (fixed at 2 in this revision).
- Clock  in  1  single clock, all flops rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- local_tile_id  in  t_tile_id  stamped into requestor_id of every outgoing request.
- ReqValid  in  [NUM_REQ-1:0]  request valid per requester.
- Req  in  t_tile_trans [NUM_REQ-1:0]  request payload; opcode WR or RD only.
- ReqReady  out  [NUM_REQ-1:0]  grant; a transfer occurs when ReqValid[i] & ReqReady[i].
- fab_ready  in  t_fab_ready (5)  fabric back-pressure.
- OutFabricValidQ505H  out  1  outbound request valid.
- OutFabricQ505H  out  t_tile_trans  outbound request.
- InFabricValidQ503H  in  1  inbound transaction valid.
- InFabricQ503H  in  t_tile_trans  inbound transaction.
- RspValid  out  [NUM_REQ-1:0]  read response to requester i; there is no back-pressure.
- RspData  out  32  read data, shared by both requesters.
- RdOutstanding  out  $clog2(MAX_RD_OUTSTANDING)+1  current FIFO occupancy.
- RspErr  out  1  sticky error flag; cleared only by Rst.

## Operation
- Issue is permitted only when fab_ready == 5'b11111 and the output stage is free or draining this cycle.
- Eligible requester: ReqValid[i], and for opcode RD additionally FIFO not full. Full is evaluated on the registered count; a pop in the same cycle does not free a slot.
- Round-robin: priority pointer rr (reset 0). With both requesters eligible, grant rr; otherwise grant the single eligible requester. After any grant, rr becomes the other requester.
- At most one ReqReady is high per cycle. ReqReady is combinational from ReqValid, count, fab_ready and rr.
- The granted payload is copied to the output register with requestor_id = local_tile_id (zero-extended). All other fields pass unchanged.
- For an RD grant, push the requester index into the tag FIFO.
- Inbound handling with InFabricValidQ503H high:
  - opcode RD_RSP with FIFO non-empty: pop the head tag h, assert RspValid[h] and drive RspData = InFabricQ503H.data in the same cycle (combinational).
  - opcode RD_RSP with FIFO empty: drop the response and set RspErr.
  - any other opcode: ignore it.
- Responses are in issue order; the fabric guarantees this for the accel core's single target.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo MAX_RD_OUTSTANDING.

## Timing
- A grant in cycle N produces OutFabricValidQ505H = 1 with the payload in cycle N+1.
- With fab_ready held all-ones, the block sustains one request per cycle.
- If fab_ready drops while the output register holds a request, that request is still presented for one cycle; no new grant is made until fab_ready returns to all-ones.
- RD_RSP-to-RspValid latency is 0 cycles.
- Reset values: OutFabricValidQ505H = 0, OutFabricQ505H = '0, ReqReady = 0, RspValid = 0, RspData = 0, RdOutstanding = 0, RspErr = 0, rr = 0, FIFO pointers = 0.
- Rst asserted mid-operation: all in-flight tags are discarded immediately (asynchronous). RD_RSPs that arrive after reset release hit an empty FIFO and set RspErr.

## Test plan
- Single WR from requester 0 (addr 32'h2200_0100, data 32'hDEAD_BEEF) with fab_ready = 5'b11111 -> ReqReady[0] = 1 in cycle N; OutFabricValidQ505H = 1 in cycle N+1 with matching payload and requestor_id = 8'h22; RdOutstanding stays 0.
- Both requesters issue continuous WRs for 6 cycles -> grants alternate 0,1,0,1,0,1; exactly one ReqReady per cycle.
- Requester 1 issues 5 RDs back-to-back with MAX_RD_OUTSTANDING = 4 -> 4 accepted; RdOutstanding = 4; 5th held with ReqReady[1] = 0. After the first RD_RSP (data 32'h1234_5678): RspValid[1] = 1, RspData = 32'h1234_5678; the 5th RD is granted the following cycle, not the same cycle.
- Interleaved RDs issued 0,1,0 with responses returned 3 cycles later in order -> RspValid pulses 0,1,0 carrying the corresponding data.
- fab_ready = 5'b11110 for 3 cycles with ReqValid = 2'b11 -> no grants and OutFabricValidQ505H = 0 after the held request drains; grants resume the cycle fab_ready returns to all-ones.
- RD_RSP with FIFO empty -> no RspValid, RspErr = 1 and stays 1. Then assert Rst with 2 reads outstanding -> RdOutstanding = 0 and all outputs at reset values within the same cycle.
